// File: rtl/lock_controller_if.sv
// Keypad strobes and blinker handshake between the lock FSM and its neighbours.
interface lock_controller_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enter_pulse;
    logic       prog_pulse;
    logic       done_blinking;
    logic       start_blinking;
    logic       blink_type;
    logic       unlocked;
    logic       locked_out;

    modport master (
        output digit_valid, digit, enter_pulse, prog_pulse, done_blinking,
        input  start_blinking, blink_type, unlocked, locked_out
    );

    modport slave (
        input  digit_valid, digit, enter_pulse, prog_pulse, done_blinking,
        output start_blinking, blink_type, unlocked, locked_out
    );
endinterface

// File: rtl/lock_controller.sv
// Digital lock FSM: keypad code entry, programming and blink requests.
// Optional failure lockout is built when LOCK_LOCKOUT_EN is defined.
//
// state    | meaning
// LOCKED   | waiting for a code; enter compares against stored code
// UNLOCKED | open; enter relocks, prog starts programming
// PROG     | collecting a new code; enter stores it if complete
// SETUP    | blink_type settled, raise start_blinking next
// BLINK    | start_blinking held until done_blinking
// LOCKOUT  | too many failures; wait LOCKOUT_CYCLES then relock
module lock_controller #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                    MAX_FAILS      = 3,
    parameter logic [31:0]           LOCKOUT_CYCLES = 32'd120000000
) (
    input logic              hwclk,
    input logic              rst_n,
    lock_controller_if.slave bus
);
    localparam int BUF_W = CODE_LEN * 4;
    localparam int CNT_W = $clog2(CODE_LEN + 1);

    typedef enum logic [2:0] {
        LOCKED, UNLOCKED, PROG, SETUP, BLINK, LOCKOUT
    } state_t;

    if (CODE_LEN < 1 || MAX_FAILS < 1 || LOCKOUT_CYCLES == 32'd0) begin : g_param_check
        $error("lock_controller: invalid parameter value");
    end

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [BUF_W-1:0]   code_q, code_d;
    logic [BUF_W-1:0]   entry_q, entry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               unlocked_q, unlocked_d;
    logic               btype_q, btype_d;
    logic               start_q, start_d;
    logic               digit_ok;
    logic               full;
    logic               match;

`ifdef LOCK_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic [31:0]        lo_cnt_q, lo_cnt_d;
`endif

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOCKED;
            ret_q      <= LOCKED;
            code_q     <= DEFAULT_CODE;
            entry_q    <= '0;
            cnt_q      <= '0;
            unlocked_q <= 1'b0;
            btype_q    <= 1'b0;
            start_q    <= 1'b0;
`ifdef LOCK_LOCKOUT_EN
            fail_q     <= '0;
            lo_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            code_q     <= code_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            unlocked_q <= unlocked_d;
            btype_q    <= btype_d;
            start_q    <= start_d;
`ifdef LOCK_LOCKOUT_EN
            fail_q     <= fail_d;
            lo_cnt_q   <= lo_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        code_d     = code_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        unlocked_d = unlocked_q;
        btype_d    = btype_q;
        start_d    = start_q;
`ifdef LOCK_LOCKOUT_EN
        fail_d     = fail_q;
        lo_cnt_d   = lo_cnt_q;
`endif
        // Enter wins over a same-cycle digit, so the digit never reaches the buffer.
        digit_ok = bus.digit_valid && (bus.digit <= 4'd9) && !bus.enter_pulse;
        full     = (cnt_q == CNT_W'(CODE_LEN));
        match    = full && (entry_q == code_q);

        case (state_q)
            LOCKED: begin
                if (bus.enter_pulse) begin
                    state_d = SETUP;
                    if (match) begin
                        unlocked_d = 1'b1;
                        btype_d    = 1'b1;
                        ret_d      = UNLOCKED;
`ifdef LOCK_LOCKOUT_EN
                        fail_d     = '0;
`endif
                    end else begin
                        btype_d = 1'b0;
                        ret_d   = LOCKED;
`ifdef LOCK_LOCKOUT_EN
                        fail_d  = fail_q + 1'b1;
                        if (fail_q >= FAIL_W'(MAX_FAILS - 1)) begin
                            ret_d = LOCKOUT;
                        end
`endif
                    end
                end
            end
            UNLOCKED: begin
                if (bus.enter_pulse) begin
                    unlocked_d = 1'b0;
                    state_d    = LOCKED;
                end else if (bus.prog_pulse) begin
                    state_d = PROG;
                end
            end
            PROG: begin
                if (bus.enter_pulse) begin
                    state_d = SETUP;
                    ret_d   = UNLOCKED;
                    if (full) begin
                        code_d  = entry_q;
                        btype_d = 1'b1;
                    end else begin
                        btype_d = 1'b0;
                    end
                end
            end
            SETUP: begin
                start_d = 1'b1;
                state_d = BLINK;
            end
            BLINK: begin
                if (bus.done_blinking) begin
                    start_d = 1'b0;
                    state_d = ret_q;
`ifdef LOCK_LOCKOUT_EN
                    lo_cnt_d = LOCKOUT_CYCLES - 32'd1;
`endif
                end
            end
            LOCKOUT: begin
`ifdef LOCK_LOCKOUT_EN
                if (lo_cnt_q == 32'd0) begin
                    state_d = LOCKED;
                    fail_d  = '0;
                end else begin
                    lo_cnt_d = lo_cnt_q - 32'd1;
                end
`else
                state_d = LOCKED;
`endif
            end
            default: state_d = LOCKED;
        endcase

        if (bus.enter_pulse || (state_d != state_q)) begin
            entry_d = '0;
            cnt_d   = '0;
        end else if (digit_ok && (state_q == LOCKED || state_q == UNLOCKED || state_q == PROG)) begin
            entry_d = (entry_q << 4) | BUF_W'(bus.digit);
            cnt_d   = full ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign bus.start_blinking = start_q;
    assign bus.blink_type     = btype_q;
    assign bus.unlocked       = unlocked_q;
`ifdef LOCK_LOCKOUT_EN
    assign bus.locked_out     = (state_q == LOCKOUT);
`else
    assign bus.locked_out     = 1'b0;
`endif
endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: expected blinks queued at stimulus, checked on start rise.
module tb_lock_controller;
    logic hwclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 hwclk = ~hwclk;

    lock_controller_if bus ();

    lock_controller #(.LOCKOUT_CYCLES(32'd100)) dut (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {logic btype; logic unl;} exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    logic prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising start_blinking must match the oldest queued expectation.
    always @(negedge hwclk) begin
        if (bus.start_blinking && !prev_start) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_blink: start rose with none expected, blink_type=%0b", bus.blink_type);
            end else begin
                mon_e = sb_q.pop_front();
                check("mon_blink_type", {31'd0, bus.blink_type}, {31'd0, mon_e.btype});
                check("mon_unlocked", {31'd0, bus.unlocked}, {31'd0, mon_e.unl});
            end
        end
        prev_start = bus.start_blinking;
    end

    // Blinker model: answers a request after three cycles, drops done once start falls.
    initial begin
        int dly;
        dly = 0;
        bus.done_blinking = 1'b0;
        forever begin
            @(negedge hwclk);
            if (!rst_n) begin
                bus.done_blinking = 1'b0;
                dly = 0;
            end else if (bus.start_blinking && !bus.done_blinking) begin
                dly++;
                if (dly >= 3) begin
                    bus.done_blinking = 1'b1;
                    dly = 0;
                end
            end else if (!bus.start_blinking) begin
                bus.done_blinking = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press_seq(input logic [31:0] digs, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.digit       = 4'((digs >> (4 * i)) & 32'hF);
            bus.digit_valid = 1'b1;
            @(negedge hwclk);
            bus.digit_valid = 1'b0;
        end
    endtask

    task automatic pulse_prog();
        bus.prog_pulse = 1'b1;
        @(negedge hwclk);
        bus.prog_pulse = 1'b0;
    endtask

    task automatic wait_blink_done(input string name);
        int k;
        k = 0;
        while (bus.start_blinking && k < 200) begin
            @(negedge hwclk);
            k++;
        end
        check({name, "_done_timeout"}, {31'd0, bus.start_blinking}, 32'd0);
    endtask

    task automatic submit(input string name, input logic [31:0] digs, input int n,
                          input logic exp_btype, input logic exp_unl, input logic with_digit);
        sb_q.push_back({exp_btype, exp_unl});
        press_seq(digs, n);
        bus.enter_pulse = 1'b1;
        if (with_digit) begin
            bus.digit       = 4'd7;
            bus.digit_valid = 1'b1;
        end
        @(negedge hwclk);
        bus.enter_pulse = 1'b0;
        bus.digit_valid = 1'b0;
        check({name, "_btype_n1"}, {31'd0, bus.blink_type}, {31'd0, exp_btype});
        check({name, "_start_n1"}, {31'd0, bus.start_blinking}, 32'd0);
        check({name, "_unl_n1"}, {31'd0, bus.unlocked}, {31'd0, exp_unl});
        @(negedge hwclk);
        check({name, "_start_n2"}, {31'd0, bus.start_blinking}, 32'd1);
        wait_blink_done(name);
        check({name, "_unl_after"}, {31'd0, bus.unlocked}, {31'd0, exp_unl});
    endtask

    task automatic relock(input string name);
        bus.enter_pulse = 1'b1;
        @(negedge hwclk);
        bus.enter_pulse = 1'b0;
        check({name, "_unl"}, {31'd0, bus.unlocked}, 32'd0);
        repeat (3) @(negedge hwclk);
        check({name, "_no_blink"}, {31'd0, bus.start_blinking}, 32'd0);
    endtask

    initial begin
        int cnt;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.enter_pulse = 1'b0;
        bus.prog_pulse  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge hwclk);
        check("rst_start", {31'd0, bus.start_blinking}, 32'd0);
        check("rst_btype", {31'd0, bus.blink_type}, 32'd0);
        check("rst_unl", {31'd0, bus.unlocked}, 32'd0);
        check("rst_lo", {31'd0, bus.locked_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge hwclk);

        submit("short_code", 32'h123, 3, 1'b0, 1'b0, 1'b0);
        submit("good_code", 32'h1234, 4, 1'b1, 1'b1, 1'b0);
        relock("relock1");

        pulse_prog();
        submit("five_digits", 32'h51234, 5, 1'b1, 1'b1, 1'b0);
        relock("relock2");

        submit("bad_digit_and_enter_digit", 32'h12C34, 5, 1'b1, 1'b1, 1'b1);
        relock("relock3");

        submit("unlock_for_prog", 32'h1234, 4, 1'b1, 1'b1, 1'b0);
        pulse_prog();
        submit("prog_short", 32'h98, 2, 1'b0, 1'b1, 1'b0);
        pulse_prog();
        submit("prog_9876", 32'h9876, 4, 1'b1, 1'b1, 1'b0);
        relock("relock4");
        submit("new_code", 32'h9876, 4, 1'b1, 1'b1, 1'b0);
        relock("relock5");
        submit("old_code", 32'h1234, 4, 1'b0, 1'b0, 1'b0);
        submit("clear_fails", 32'h9876, 4, 1'b1, 1'b1, 1'b0);
        relock("relock6");

        submit("wrong1", 32'h1111, 4, 1'b0, 1'b0, 1'b0);
        submit("wrong2", 32'h1111, 4, 1'b0, 1'b0, 1'b0);
        submit("wrong3", 32'h1111, 4, 1'b0, 1'b0, 1'b0);
`ifdef LOCK_LOCKOUT_EN
        check("lo_enter", {31'd0, bus.locked_out}, 32'd1);
        cnt = 0;
        while (bus.locked_out && cnt < 300) begin
            cnt++;
            bus.digit_valid = (cnt >= 10 && cnt <= 13);
            bus.digit       = 4'((32'h9876 >> (4 * (13 - cnt))) & 32'hF);
            bus.enter_pulse = (cnt == 14);
            @(negedge hwclk);
        end
        bus.digit_valid = 1'b0;
        bus.enter_pulse = 1'b0;
        check("lo_length", cnt, 32'd100);
        check("lo_code_ignored", {31'd0, bus.unlocked}, 32'd0);
        submit("after_lo_wrong", 32'h1111, 4, 1'b0, 1'b0, 1'b0);
        check("after_lo_fails_cleared", {31'd0, bus.locked_out}, 32'd0);
`else
        check("no_lockout", {31'd0, bus.locked_out}, 32'd0);
`endif
        submit("after_fails_unlock", 32'h9876, 4, 1'b1, 1'b1, 1'b0);
        relock("relock7");

        // Reset in the middle of a success blink.
        sb_q.push_back({1'b1, 1'b1});
        press_seq(32'h9876, 4);
        bus.enter_pulse = 1'b1;
        @(negedge hwclk);
        bus.enter_pulse = 1'b0;
        cnt = 0;
        while (!bus.start_blinking && cnt < 10) begin
            @(negedge hwclk);
            cnt++;
        end
        check("mid_blink_start_seen", {31'd0, bus.start_blinking}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", {31'd0, bus.start_blinking}, 32'd0);
        check("mid_rst_unl", {31'd0, bus.unlocked}, 32'd0);
        repeat (2) @(negedge hwclk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge hwclk);
            if (bus.start_blinking) cnt++;
        end
        check("no_rerequest", cnt, 32'd0);
        submit("default_code_back", 32'h1234, 4, 1'b1, 1'b1, 1'b0);

        repeat (2) @(negedge hwclk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
